// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath.
// Sequences fetch/decode/execute/memory/writeback from the latched opcode.
// It drives the aluop consumed by the ALU control decoder and all datapath strobes.
// A ready-based memory handshake has a timeout trap, and a retired-instruction counter is kept.
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      op,
  input  logic             mem_ready,
  output logic [1:0]       aluop,
  output logic             alusrc,
  output logic             reg2loc,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcwrite_cond,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             trap,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    EXEC_I = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    TRAP   = 4'd15
  } state_e;

  // The last low cycle that is still tolerated before the trap fires
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       aluopHold_q, aluopHold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] aluop_c;
  logic       alusrc_c, reg2loc_c, iord_c, memread_c, memwrite_c, irwrite_c;
  logic       pcwrite_c, pcwrite_cond_c, memtoreg_c, regwrite_c, retire_c, trap_c;
  logic       waitState, timeout;

  // Next-state and unqualified strobe decode for the current state
  always_comb begin
    state_d        = state_q;
    aluop_c        = 2'b00;
    alusrc_c       = 1'b0;
    reg2loc_c      = 1'b0;
    iord_c         = 1'b0;
    memread_c      = 1'b0;
    memwrite_c     = 1'b0;
    irwrite_c      = 1'b0;
    pcwrite_c      = 1'b0;
    pcwrite_cond_c = 1'b0;
    memtoreg_c     = 1'b0;
    regwrite_c     = 1'b0;
    retire_c       = 1'b0;
    trap_c         = 1'b0;
    waitState      = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    timeout        = !mem_ready && (wait_q == WAIT_LAST);

    case (state_q)
      FETCH: begin
        memread_c = 1'b1;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
          state_d   = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        casez (op)
          11'b11111000010, 11'b11111000000:                             state_d = MEMADR;
          11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: state_d = EXEC_R;
          11'b1001000100?:                                              state_d = EXEC_I;
          11'b10110100???:                                              state_d = BRANCH;
          default:                                                      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        aluop_c  = 2'b00;
        alusrc_c = 1'b1;
        state_d  = op[1] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) begin
          state_d = MEMWB;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        reg2loc_c  = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = FETCH;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      EXEC_R: begin
        aluop_c = 2'b10;
        state_d = ALUWB;
      end
      EXEC_I: begin
        aluop_c  = 2'b11;
        alusrc_c = 1'b1;
        state_d  = ALUWB;
      end
      ALUWB: begin
        aluop_c    = aluopHold_q;
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        aluop_c        = 2'b01;
        reg2loc_c      = 1'b1;
        pcwrite_cond_c = 1'b1;
        retire_c       = 1'b1;
        state_d        = FETCH;
      end
      TRAP: begin
        trap_c = 1'b1;
      end
      default: begin
        state_d = TRAP;
      end
    endcase

    wait_d      = (waitState && (state_d == state_q) && !mem_ready) ? wait_q + 8'd1 : 8'd0;
    aluopHold_d = ((state_q == EXEC_R) || (state_q == EXEC_I)) ? aluop_c : aluopHold_q;
    cnt_d       = retire_c ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State, wait counter, held aluop and retire counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      wait_q      <= 8'd0;
      aluopHold_q <= 2'b00;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      aluopHold_q <= aluopHold_d;
      cnt_q       <= cnt_d;
    end
  end

  // Every strobe is gated by reset, so FETCH does not request memory while reset is held
  assign aluop        = reset ? aluop_c : 2'b00;
  assign alusrc       = reset & alusrc_c;
  assign reg2loc      = reset & reg2loc_c;
  assign iord         = reset & iord_c;
  assign memread      = reset & memread_c;
  assign memwrite     = reset & memwrite_c;
  assign irwrite      = reset & irwrite_c;
  assign pcwrite      = reset & pcwrite_c;
  assign pcwrite_cond = reset & pcwrite_cond_c;
  assign memtoreg     = reset & memtoreg_c;
  assign regwrite     = reset & regwrite_c;
  assign retire       = reset & retire_c;
  assign trap         = reset & trap_c;
  assign retired_cnt  = cnt_q;
  assign state        = state_q;

endmodule
